dll_fc_update_scheduler: RTL and testbench
==========================================

DLL_FC_UPDATE_SCHEDULER -- requirements
Module: dll_fc_update_scheduler

Interface
REQ-001 SHALL have parameter UPDATE_PERIOD, default 1024: cycles between periodic refreshes of all three FC types.
REQ-002 SHALL have parameter ACK_TIMEOUT, default 4: cycles to wait for the generator before abandoning a request.
REQ-003 SHALL use one clock and a synchronous, active-high reset.
REQ-004 clk  in  1  sole clock, all state updates on its rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 dlc_state_i  in  2  DLCMSM state; 2'b11 = DL_Active.
REQ-007 p_hdr_credit_i / np_hdr_credit_i / cpl_hdr_credit_i  in  8 each  current header credit per type.
REQ-008 p_data_credit_i / np_data_credit_i / cpl_data_credit_i  in  12 each  current data credit per type.
REQ-009 credit_ret_i  in  3  one-cycle pulse per type (bit0 P, bit1 NP, bit2 Cpl): receive buffer freed.
REQ-010 dllp_valid_i  in  1  generator DLLP-emitted pulse, used as the acknowledge.
REQ-011 update_req_o  out  1  one-cycle request to the DLLP generator.
REQ-012 update_type_o  out  2  00 P, 01 NP, 10 Cpl.
REQ-013 hdr_credit_o  out  8; data_credit_o  out  12: credits of the granted type.
REQ-014 pending_o  out  3  per-type pending flags, for debug.

Function
REQ-015 SHALL hold one pending bit per type; pending[i] set by credit_ret_i[i], by entry into DL_Active (all three, on the first cycle dlc_state_i==11 after != 11), or by timer expiry (all three).
REQ-016 A pending bit SHALL clear only when its type is granted; a set condition in the same cycle as the grant wins, leaving the bit set.
REQ-017 FSM states: IDLE, REQ, WAIT.
REQ-018 IDLE -> REQ when dlc_state_i==11 and any pending bit is set; otherwise stay in IDLE.
REQ-019 On the IDLE->REQ edge, SHALL choose the type round-robin starting after the last granted type (order P, NP, Cpl; initial pointer on Cpl so P wins first).
REQ-020 On the IDLE->REQ edge, SHALL register update_type_o and that type's hdr/data credit inputs.
REQ-021 In REQ, update_req_o SHALL be 1 for exactly one cycle; outputs stay stable until the next grant; next state WAIT; the granted pending bit clears on this cycle, subject to REQ-016.
REQ-022 In WAIT, dllp_valid_i==1 -> IDLE and advance the RR pointer to the granted type.
REQ-023 Expected latency: update_req_o at cycle T, dllp_valid_i at T+2; the minimum spacing between successive update_req_o pulses is 4 cycles.
REQ-024 In WAIT, dlc_state_i!=11 or ACK_TIMEOUT cycles without dllp_valid_i -> IDLE, re-set the granted pending bit, and leave the RR pointer unchanged.
REQ-025 A dllp_valid_i seen outside WAIT SHALL be ignored.
REQ-026 While dlc_state_i!=11: no requests are issued; pending bits are retained; the timer is held at 0.
REQ-027 The timer width SHALL be $clog2(UPDATE_PERIOD+1); it counts in DL_Active, and on reaching UPDATE_PERIOD-1 it sets all pending bits and wraps to 0.

Reset
REQ-028 On rst: state IDLE; pending 000; RR pointer Cpl; timer 0; update_req_o 0; update_type_o 00; hdr_credit_o 0; data_credit_o 0.
REQ-029 rst asserted mid-WAIT SHALL abandon the transaction with no further update_req_o pulse.

Configuration
REQ-030 Macro DLL_FC_PERIODIC_UPDATE_EN: when defined, the timer of REQ-027 is built in.
REQ-031 When DLL_FC_PERIODIC_UPDATE_EN is undefined: no timer logic; updates are issued only from credit_ret_i and DL_Active entry; UPDATE_PERIOD is unused.

Structure
REQ-032 Package dll_pkg SHALL hold the DLC_DL_ACTIVE constant, the FC type enum (P/NP/CPL), and the scheduler state enum.
REQ-033 The round-robin pick SHALL be a sub-module dll_rr_arb3: 3 requests, pointer input, one-hot grant output.

Verification
REQ-034 DL_Active entry with P/NP/Cpl hdr 8'h20/8'h10/8'h08 -> three update_req_o pulses, types 00, 01, 10 in order, each with the matching hdr credit, spaced 4 cycles with a T+2 acknowledge.
REQ-035 credit_ret_i=3'b110 in IDLE after a last grant of NP -> Cpl is granted first, then NP.
REQ-036 credit_ret_i[0] pulsed on the same cycle as the P grant -> P is requested a second time after the acknowledge.
REQ-037 dllp_valid_i withheld -> after 4 cycles in WAIT, return to IDLE, pending re-set, the same type re-requested.
REQ-038 dlc_state_i drops to 00 during WAIT -> IDLE, no request; on return to 11, all three types are requested.
REQ-039 With DLL_FC_PERIODIC_UPDATE_EN defined and UPDATE_PERIOD=16, idle in DL_Active -> a burst of three requests every 16 cycles; with the macro undefined -> no requests.

Source files
------------

// File: rtl/dll_pkg.sv
// Shared types for the DLL flow-control update scheduler: link state code, FC type, scheduler state.
// No logic or latency of its own; no flow control.
// Includes one-hot/type conversion helpers used by the scheduler.
package dll_pkg;

    localparam logic [1:0] DLC_DL_ACTIVE = 2'b11;

    typedef enum logic [1:0] {
        FC_P   = 2'b00,
        FC_NP  = 2'b01,
        FC_CPL = 2'b10
    } fc_type_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_REQ  = 2'b01,
        S_WAIT = 2'b10
    } sched_state_e;

    function automatic fc_type_e onehot_to_type(input logic [2:0] oh);
        if (oh[2]) return FC_CPL;
        if (oh[1]) return FC_NP;
        return FC_P;
    endfunction

    function automatic logic [2:0] type_to_onehot(input fc_type_e t);
        case (t)
            FC_P:    return 3'b001;
            FC_NP:   return 3'b010;
            default: return 3'b100;
        endcase
    endfunction

endpackage

// File: rtl/dll_rr_arb3.sv
// Three-way round-robin pick: the first requester after i_ptr in P, NP, Cpl order wins.
// Purely combinational, zero latency.
// No backpressure; the caller samples o_gnt when it is ready to grant.
module dll_rr_arb3
    import dll_pkg::*;
(
    input  logic [2:0] i_req,
    input  fc_type_e   i_ptr,
    output logic [2:0] o_gnt
);

    always_comb begin
        o_gnt = 3'b000;
        case (i_ptr)
            FC_P: begin
                if      (i_req[1]) o_gnt = 3'b010;
                else if (i_req[2]) o_gnt = 3'b100;
                else if (i_req[0]) o_gnt = 3'b001;
            end
            FC_NP: begin
                if      (i_req[2]) o_gnt = 3'b100;
                else if (i_req[0]) o_gnt = 3'b001;
                else if (i_req[1]) o_gnt = 3'b010;
            end
            default: begin
                if      (i_req[0]) o_gnt = 3'b001;
                else if (i_req[1]) o_gnt = 3'b010;
                else if (i_req[2]) o_gnt = 3'b100;
            end
        endcase
    end

endmodule

// File: rtl/dll_fc_update_scheduler.sv
// Schedules UpdateFC DLLP requests per FC type; periodic refresh timer only with DLL_FC_PERIODIC_UPDATE_EN.
// Latency: request two cycles after a pending bit sets; one request per 4 cycles with a T+2 acknowledge.
// Backpressure: waits ACK_TIMEOUT cycles for dllp_valid_i, then re-arms the type and retries.
module dll_fc_update_scheduler
    import dll_pkg::*;
#(
    parameter int UPDATE_PERIOD = 1024,
    parameter int ACK_TIMEOUT   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  dlc_state_i,
    input  logic [7:0]  p_hdr_credit_i,
    input  logic [7:0]  np_hdr_credit_i,
    input  logic [7:0]  cpl_hdr_credit_i,
    input  logic [11:0] p_data_credit_i,
    input  logic [11:0] np_data_credit_i,
    input  logic [11:0] cpl_data_credit_i,
    input  logic [2:0]  credit_ret_i,
    input  logic        dllp_valid_i,
    output logic        update_req_o,
    output logic [1:0]  update_type_o,
    output logic [7:0]  hdr_credit_o,
    output logic [11:0] data_credit_o,
    output logic [2:0]  pending_o
);

    localparam int WCNT_W = $clog2(ACK_TIMEOUT + 1);

    sched_state_e      r_state;
    fc_type_e          r_last;
    fc_type_e          r_type;
    logic [2:0]        r_pend;
    logic              r_prev_act;
    logic              r_req;
    logic [7:0]        r_hdr;
    logic [11:0]       r_data;
    logic [WCNT_W-1:0] r_wcnt;

    logic        w_active;
    logic        w_entry;
    logic        w_tmr_exp;
    logic        w_abort;
    logic [2:0]  w_set;
    logic [2:0]  w_clr;
    logic [2:0]  w_rearm;
    logic [2:0]  w_gnt;
    fc_type_e    w_gnt_type;
    logic [7:0]  w_hdr_sel;
    logic [11:0] w_data_sel;

    assign w_active = (dlc_state_i == DLC_DL_ACTIVE);
    assign w_entry  = w_active & ~r_prev_act;

`ifdef DLL_FC_PERIODIC_UPDATE_EN
    localparam int TMR_W = $clog2(UPDATE_PERIOD + 1);
    logic [TMR_W-1:0] r_tmr;

    assign w_tmr_exp = w_active && (r_tmr == TMR_W'(UPDATE_PERIOD - 1));

    // Held at zero outside DL_Active so the first refresh is a full period after entry.
    always_ff @(posedge clk) begin
        if (rst || !w_active || w_tmr_exp) r_tmr <= '0;
        else                               r_tmr <= r_tmr + TMR_W'(1);
    end
`else
    assign w_tmr_exp = 1'b0;
`endif

    dll_rr_arb3 u_arb (
        .i_req (r_pend),
        .i_ptr (r_last),
        .o_gnt (w_gnt)
    );

    assign w_gnt_type = onehot_to_type(w_gnt);
    assign w_set      = credit_ret_i | {3{w_entry | w_tmr_exp}};
    assign w_abort    = (r_state == S_WAIT) && !dllp_valid_i &&
                        (!w_active || (r_wcnt == WCNT_W'(ACK_TIMEOUT - 1)));

    always_comb begin
        w_hdr_sel  = p_hdr_credit_i;
        w_data_sel = p_data_credit_i;
        if (w_gnt[1]) begin
            w_hdr_sel  = np_hdr_credit_i;
            w_data_sel = np_data_credit_i;
        end
        if (w_gnt[2]) begin
            w_hdr_sel  = cpl_hdr_credit_i;
            w_data_sel = cpl_data_credit_i;
        end
    end

    // Set terms are ORed after the clear, so a same-cycle set survives the grant.
    assign w_clr   = (r_state == S_REQ) ? type_to_onehot(r_type) : 3'b000;
    assign w_rearm = w_abort ? type_to_onehot(r_type) : 3'b000;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_pend     <= 3'b000;
            r_last     <= FC_CPL;
            r_type     <= FC_P;
            r_hdr      <= '0;
            r_data     <= '0;
            r_req      <= 1'b0;
            r_prev_act <= 1'b0;
            r_wcnt     <= '0;
        end else begin
            r_prev_act <= w_active;
            r_pend     <= (r_pend & ~w_clr) | w_set | w_rearm;
            r_req      <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_active && (|r_pend)) begin
                        r_state <= S_REQ;
                        r_req   <= 1'b1;
                        r_type  <= w_gnt_type;
                        r_hdr   <= w_hdr_sel;
                        r_data  <= w_data_sel;
                    end
                end
                S_REQ: begin
                    r_state <= S_WAIT;
                    r_wcnt  <= '0;
                end
                S_WAIT: begin
                    if (dllp_valid_i) begin
                        r_state <= S_IDLE;
                        r_last  <= r_type;
                    end else if (w_abort) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_wcnt <= r_wcnt + WCNT_W'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign update_req_o  = r_req;
    assign update_type_o = r_type;
    assign hdr_credit_o  = r_hdr;
    assign data_credit_o = r_data;
    assign pending_o     = r_pend;

endmodule

// File: tb/tb_dll_fc_update_scheduler.sv
// Bench for dll_fc_update_scheduler: directed scenarios then random traffic against a transaction-age model.
// Inputs change 1 ns after each rising edge; outputs are sampled at the same point.
module tb_dll_fc_update_scheduler;

    localparam int PERIOD = 16;
    localparam int TMO    = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  dlc;
    logic [7:0]  hdr_in [3];
    logic [11:0] dat_in [3];
    logic [2:0]  cret;
    logic        dllp_valid;
    logic        update_req_o;
    logic [1:0]  update_type_o;
    logic [7:0]  hdr_credit_o;
    logic [11:0] data_credit_o;
    logic [2:0]  pending_o;

    always #5 clk = ~clk;

    dll_fc_update_scheduler #(.UPDATE_PERIOD(PERIOD), .ACK_TIMEOUT(TMO)) dut (
        .clk               (clk),
        .rst               (rst),
        .dlc_state_i       (dlc),
        .p_hdr_credit_i    (hdr_in[0]),
        .np_hdr_credit_i   (hdr_in[1]),
        .cpl_hdr_credit_i  (hdr_in[2]),
        .p_data_credit_i   (dat_in[0]),
        .np_data_credit_i  (dat_in[1]),
        .cpl_data_credit_i (dat_in[2]),
        .credit_ret_i      (cret),
        .dllp_valid_i      (dllp_valid),
        .update_req_o      (update_req_o),
        .update_type_o     (update_type_o),
        .hdr_credit_o      (hdr_credit_o),
        .data_credit_o     (data_credit_o),
        .pending_o         (pending_o)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: m_age is cycles since the request pulse (-1 = no transaction open).
    int          m_age;
    int          m_last;
    int          m_type;
    logic [2:0]  m_pend;
    logic        m_prev;
    logic [7:0]  m_hdr;
    logic [11:0] m_data;
`ifdef DLL_FC_PERIODIC_UPDATE_EN
    int          m_tmr;
`endif

    task automatic model_step();
        logic       act;
        logic       found;
        logic [2:0] set;
        logic [2:0] clr;
        logic [2:0] ab;
        int         nxt;
        int         idx;
        if (rst) begin
            m_age = -1; m_pend = 3'b000; m_last = 2; m_type = 0;
            m_hdr = 8'h00; m_data = 12'h000; m_prev = 1'b0;
`ifdef DLL_FC_PERIODIC_UPDATE_EN
            m_tmr = 0;
`endif
            return;
        end
        act = (dlc == 2'b11);
        set = cret;
        if (act && !m_prev) set = 3'b111;
`ifdef DLL_FC_PERIODIC_UPDATE_EN
        if (act && m_tmr == PERIOD - 1) set = 3'b111;
        m_tmr = (act && m_tmr != PERIOD - 1) ? m_tmr + 1 : 0;
`endif
        m_prev = act;
        clr = 3'b000;
        ab  = 3'b000;
        nxt = m_age;
        if (m_age < 0) begin
            if (act && m_pend != 3'b000) begin
                found = 1'b0;
                for (int k = 1; k <= 3; k++) begin
                    idx = (m_last + k) % 3;
                    if (!found && m_pend[idx]) begin
                        found  = 1'b1;
                        m_type = idx;
                    end
                end
                m_hdr  = hdr_in[m_type];
                m_data = dat_in[m_type];
                nxt    = 0;
            end
        end else if (m_age == 0) begin
            clr[m_type] = 1'b1;
            nxt = 1;
        end else if (dllp_valid) begin
            m_last = m_type;
            nxt    = -1;
        end else if (!act || m_age == TMO) begin
            ab[m_type] = 1'b1;
            nxt = -1;
        end else begin
            nxt = m_age + 1;
        end
        m_pend = (m_pend & ~clr) | set | ab;
        m_age  = nxt;
    endtask

    int   cyc        = 0;
    int   ack_dly    = 0;
    int   ack_cfg    = 2;
    bit   rnd_mode   = 1'b0;
    bit   p_on_grant = 1'b0;
    int   lg_type[$];
    int   lg_hdr[$];
    int   lg_cyc[$];

    function automatic int pick_delay();
        case ($urandom_range(0, 9))
            6:       return 1;
            7:       return 3;
            8:       return 5;
            9:       return 0;
            default: return 2;
        endcase
    endfunction

    task automatic clear_log();
        lg_type.delete();
        lg_hdr.delete();
        lg_cyc.delete();
    endtask

    task automatic cycle(input logic [1:0] d, input logic r, input logic [2:0] cr);
        logic v;
        @(posedge clk);
        #1;
        cyc++;
        chk("req",  32'(update_req_o),  32'(m_age == 0));
        chk("type", 32'(update_type_o), 32'(m_type));
        chk("hdr",  32'(hdr_credit_o),  32'(m_hdr));
        chk("data", 32'(data_credit_o), 32'(m_data));
        chk("pend", 32'(pending_o),     32'(m_pend));
        if (update_req_o === 1'b1) begin
            lg_type.push_back(int'(update_type_o));
            lg_hdr.push_back(int'(hdr_credit_o));
            lg_cyc.push_back(cyc);
        end
        v = 1'b0;
        if (ack_dly > 0) begin
            ack_dly--;
            v = (ack_dly == 0);
        end
        if (m_age == 0) ack_dly = rnd_mode ? pick_delay() : ack_cfg;
        if (rnd_mode && $urandom_range(0, 15) == 0) v = 1'b1;
        if (p_on_grant && m_age == 0 && m_type == 0) begin
            cr = cr | 3'b001;
            p_on_grant = 1'b0;
        end
        if (rnd_mode) begin
            for (int i = 0; i < 3; i++) begin
                hdr_in[i] = 8'($urandom);
                dat_in[i] = 12'($urandom);
            end
        end
        dlc = d; rst = r; cret = cr; dllp_valid = v;
        model_step();
    endtask

    logic [1:0] dlc_r;
    int         mask;

    initial begin
        rst = 1'b1; dlc = 2'b00; cret = 3'b000; dllp_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            hdr_in[i] = 8'h00;
            dat_in[i] = 12'h000;
        end
        model_step();
        cycle(2'b00, 1'b1, 3'b000);
        cycle(2'b00, 1'b0, 3'b000);
        chk("rst_req",  32'(update_req_o),  32'd0);
        chk("rst_type", 32'(update_type_o), 32'd0);
        chk("rst_hdr",  32'(hdr_credit_o),  32'd0);
        chk("rst_data", 32'(data_credit_o), 32'd0);
        chk("rst_pend", 32'(pending_o),     32'd0);

        // DL_Active entry: three requests P, NP, Cpl carrying their own header credits.
        hdr_in[0] = 8'h20; hdr_in[1] = 8'h10; hdr_in[2] = 8'h08;
        dat_in[0] = 12'h111; dat_in[1] = 12'h222; dat_in[2] = 12'h333;
        clear_log();
        for (int i = 0; i < 16; i++) cycle(2'b11, 1'b0, 3'b000);
        chk("entry_n",    32'(lg_type.size()), 32'd3);
        chk("entry_t0",   32'(lg_type[0]), 32'd0);
        chk("entry_t1",   32'(lg_type[1]), 32'd1);
        chk("entry_t2",   32'(lg_type[2]), 32'd2);
        chk("entry_h0",   32'(lg_hdr[0]),  32'h20);
        chk("entry_h1",   32'(lg_hdr[1]),  32'h10);
        chk("entry_h2",   32'(lg_hdr[2]),  32'h08);
        chk("entry_gap1", 32'(lg_cyc[1] - lg_cyc[0]), 32'd4);
        chk("entry_gap2", 32'(lg_cyc[2] - lg_cyc[1]), 32'd4);

        // Idle in DL_Active: periodic bursts only when the refresh timer is built.
        clear_log();
        for (int i = 0; i < 64; i++) cycle(2'b11, 1'b0, 3'b000);
`ifdef DLL_FC_PERIODIC_UPDATE_EN
        chk("period_n",   32'(lg_type.size()), 32'd12);
        chk("period_gap", 32'(lg_cyc[3] - lg_cyc[0]), 32'(PERIOD));
`else
        chk("idle_n", 32'(lg_type.size()), 32'd0);
`endif

        // Last grant NP, then Cpl+NP returned together: Cpl wins first.
        cycle(2'b11, 1'b0, 3'b010);
        for (int i = 0; i < 8; i++) cycle(2'b11, 1'b0, 3'b000);
        clear_log();
        cycle(2'b11, 1'b0, 3'b110);
        for (int i = 0; i < 10; i++) cycle(2'b11, 1'b0, 3'b000);
`ifndef DLL_FC_PERIODIC_UPDATE_EN
        chk("rr_n",  32'(lg_type.size()), 32'd2);
        chk("rr_t0", 32'(lg_type[0]), 32'd2);
        chk("rr_t1", 32'(lg_type[1]), 32'd1);
`endif

        // Credit return on the P grant cycle keeps P pending: P requested twice.
        clear_log();
        p_on_grant = 1'b1;
        cycle(2'b11, 1'b0, 3'b001);
        for (int i = 0; i < 11; i++) cycle(2'b11, 1'b0, 3'b000);
`ifndef DLL_FC_PERIODIC_UPDATE_EN
        chk("setwin_n",  32'(lg_type.size()), 32'd2);
        chk("setwin_t0", 32'(lg_type[0]), 32'd0);
        chk("setwin_t1", 32'(lg_type[1]), 32'd0);
`endif

        // Acknowledge withheld: same type retried after the timeout.
        clear_log();
        ack_cfg = 0;
        cycle(2'b11, 1'b0, 3'b010);
        for (int i = 0; i < 3; i++) cycle(2'b11, 1'b0, 3'b000);
        ack_cfg = 2;
        for (int i = 0; i < 10; i++) cycle(2'b11, 1'b0, 3'b000);
`ifndef DLL_FC_PERIODIC_UPDATE_EN
        chk("tmo_n",   32'(lg_type.size()), 32'd2);
        chk("tmo_t1",  32'(lg_type[1]), 32'd1);
        chk("tmo_gap", 32'(lg_cyc[1] - lg_cyc[0]), 32'(TMO + 2));
`endif

        // Link drops during WAIT: nothing issued while down, all three on return.
        ack_cfg = 0;
        cycle(2'b11, 1'b0, 3'b100);
        for (int i = 0; i < 3; i++) cycle(2'b11, 1'b0, 3'b000);
        cycle(2'b00, 1'b0, 3'b000);
        clear_log();
        for (int i = 0; i < 6; i++) cycle(2'b00, 1'b0, 3'b000);
        chk("down_n", 32'(lg_type.size()), 32'd0);
        ack_cfg = 2;
        clear_log();
        for (int i = 0; i < 14; i++) cycle(2'b11, 1'b0, 3'b000);
        mask = 0;
        foreach (lg_type[i]) mask = mask | (1 << lg_type[i]);
        chk("up_n",    32'(lg_type.size()), 32'd3);
        chk("up_mask", 32'(mask), 32'd7);

        // Reset while waiting for the acknowledge abandons the transaction.
        ack_cfg = 0;
        cycle(2'b11, 1'b0, 3'b001);
        for (int i = 0; i < 3; i++) cycle(2'b11, 1'b0, 3'b000);
        cycle(2'b00, 1'b1, 3'b000);
        clear_log();
        for (int i = 0; i < 6; i++) cycle(2'b00, 1'b0, 3'b000);
        chk("rstw_n",    32'(lg_type.size()), 32'd0);
        chk("rstw_pend", 32'(pending_o), 32'd0);
        ack_cfg = 2;

        // Random traffic: link flaps, credit returns, late/missing/spurious acks, resets.
        rnd_mode = 1'b1;
        dlc_r = 2'b11;
        for (int n = 0; n < 2500; n++) begin
            if ($urandom_range(0, 39) == 0)
                dlc_r = ($urandom_range(0, 3) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            else if (dlc_r != 2'b11 && $urandom_range(0, 5) == 0)
                dlc_r = 2'b11;
            cycle(dlc_r, ($urandom_range(0, 299) == 0),
                  ($urandom_range(0, 7) == 0) ? 3'($urandom) : 3'b000);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
